systolic_feeder: RTL

- Upstream stage of the 3x3 output-stationary MAC systolic array.
- Accepts one pair of 3x3 operand matrices A and B through a valid/ready handshake and issues the diagonally-skewed left (row) and top (column) operand streams.
- Drives the array enable and accumulator-clear, counts the drain window, and signals completion with a one-cycle done pulse.
- After done, array cell (r,c) holds C[r][c] = sum over k of A[r][k]*B[k][c].

---
 rtl/systolic_feeder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for the 3x3 output-stationary MAC systolic array.
// Captures one A/B operand pair through a valid/ready handshake, then issues
// the diagonally skewed row and column streams. It also drives the array
// enable and accumulator clear, counts the drain window, and pulses done.
module systolic_feeder #(
    parameter int MATRIX_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [9*DATA_WIDTH-1:0] a_flat,
    input  logic [9*DATA_WIDTH-1:0] b_flat,
    input  logic                    hold,
    output logic [DATA_WIDTH-1:0]   left_0,
    output logic [DATA_WIDTH-1:0]   left_1,
    output logic [DATA_WIDTH-1:0]   left_2,
    output logic [DATA_WIDTH-1:0]   top_0,
    output logic [DATA_WIDTH-1:0]   top_1,
    output logic [DATA_WIDTH-1:0]   top_2,
    output logic                    array_en,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    done
);

    // The feed phase skews a 3-element row across 3 lanes, giving 2N-1 steps.
    localparam int FEED_STEPS = 2 * MATRIX_SIZE - 1;
    localparam int CNT_MAX    = (FEED_STEPS > DRAIN_CYCLES) ? FEED_STEPS : DRAIN_CYCLES;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_STEPS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cntNext;
    logic                  w_transfer;

    logic [DATA_WIDTH-1:0] r_aMat [3][3];
    logic [DATA_WIDTH-1:0] r_bMat [3][3];

    logic [DATA_WIDTH-1:0] r_left [3];
    logic [DATA_WIDTH-1:0] r_top  [3];
    logic [DATA_WIDTH-1:0] w_leftNext [3];
    logic [DATA_WIDTH-1:0] w_topNext  [3];

    assign w_transfer = start_valid && (r_state == S_IDLE);

    // Next-state and step-counter logic; hold freezes FEED and DRAIN only.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_stateNext = S_CLEAR;
                    w_cntNext   = '0;
                end
            end
            S_CLEAR: begin
                w_stateNext = S_FEED;
                w_cntNext   = '0;
            end
            S_FEED: begin
                if (!hold) begin
                    if (r_cnt == FEED_LAST) begin
                        w_cntNext = '0;
                        if (DRAIN_CYCLES == 0) begin
                            w_stateNext = S_DONE;
                        end else begin
                            w_stateNext = S_DRAIN;
                        end
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!hold) begin
                    if (r_cnt == DRAIN_LAST) begin
                        w_stateNext = S_DONE;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
                w_cntNext   = '0;
            end
            default: begin
                w_stateNext = S_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // State and step counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Operand capture on the handshake edge; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_aMat[r][c] <= '0;
                    r_bMat[r][c] <= '0;
                end
            end
        end else if (w_transfer) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_aMat[r][c] <= a_flat[(r*3+c)*DATA_WIDTH +: DATA_WIDTH];
                    r_bMat[r][c] <= b_flat[(r*3+c)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Skewed operand selection for the step the counter is about to hold:
    // lane i carries element k of its row/column when step == i + k.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_leftNext[i] = '0;
            w_topNext[i]  = '0;
        end
        if (w_stateNext == S_FEED) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (int'(w_cntNext) == i + k) begin
                        w_leftNext[i] = r_aMat[i][k];
                        w_topNext[i]  = r_bMat[k][i];
                    end
                end
            end
        end
    end

    // Registered stream outputs, loaded so each step's values appear while
    // the counter shows that step; a held step reloads the same values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                r_left[i] <= '0;
                r_top[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_left[i] <= w_leftNext[i];
                r_top[i]  <= w_topNext[i];
            end
        end
    end

    assign left_0 = r_left[0];
    assign left_1 = r_left[1];
    assign left_2 = r_left[2];
    assign top_0  = r_top[0];
    assign top_1  = r_top[1];
    assign top_2  = r_top[2];

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign acc_clr     = (r_state == S_CLEAR);
    assign done        = (r_state == S_DONE);
    assign array_en    = ((r_state == S_FEED) || (r_state == S_DRAIN)) && !hold;

endmodule
